// File: rtl/a0_uart_monitor.sv
// a0_uart_monitor: queues each change of the CPU a0 register and sends it MSB byte first over UART 8N1.
module a0_uart_monitor #(
   parameter int DATA_WIDTH   = 32,
   parameter int CLKS_PER_BIT = 16,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic [DATA_WIDTH-1:0] a0,
   output logic                  tx,
   output logic                  busy,
   output logic                  overflow,
   output logic [15:0]           sent_count
);
   localparam int BYTES = DATA_WIDTH / 8;
   localparam int AW    = $clog2(FIFO_DEPTH);
   localparam int TW    = $clog2(CLKS_PER_BIT);
   localparam int BW    = BYTES > 1 ? $clog2(BYTES) : 1;
   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
   state_t                r_state, w_next;
   logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
   logic [DATA_WIDTH-1:0] r_prev, r_word;
   logic [AW-1:0]         r_wr, r_rd;
   logic [AW:0]           r_count;
   logic [TW-1:0]         r_timer;
   logic [2:0]            r_bit, w_bit;
   logic [BW-1:0]         r_byte;
   logic [15:0]           r_sent;
   logic                  r_tx, r_ovf;
   logic                  w_tick, w_last, w_full, w_push, w_pop, w_accept, w_tx;
   logic [7:0]            w_cur;
   assign w_tick   = r_timer == TW'(CLKS_PER_BIT - 1);
   assign w_last   = r_byte == BW'(BYTES - 1);
   assign w_full   = r_count == (AW+1)'(FIFO_DEPTH);
   assign w_push   = en && (a0 != r_prev);
   // Pop only from a non-empty FIFO: no same-edge bypass of a fresh push.
   assign w_pop    = (r_count != '0) && (r_state == S_IDLE || (r_state == S_STOP && w_tick && w_last));
   assign w_accept = w_push && (!w_full || w_pop);
   assign w_cur    = r_word[DATA_WIDTH-1 -: 8];
   assign w_bit    = (r_state == S_DATA && w_tick) ? r_bit + 3'd1 : r_bit;
   assign tx         = r_tx;
   assign busy       = (r_state != S_IDLE) || (r_count != '0);
   assign overflow   = r_ovf;
   assign sent_count = r_sent;
   always_ff @(posedge clk or negedge rst)
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_next;
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (r_count != '0) w_next = S_START;
         S_START: if (w_tick) w_next = S_DATA;
         S_DATA:  if (w_tick && r_bit == 3'd7) w_next = S_STOP;
         default: if (w_tick) w_next = (!w_last || r_count != '0) ? S_START : S_IDLE;
      endcase
   end
   always_comb
      w_tx = (w_next == S_START) ? 1'b0 : (w_next == S_DATA) ? w_cur[w_bit] : 1'b1;
   always_ff @(posedge clk)
      if (w_accept) r_mem[r_wr] <= a0;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_tx    <= 1'b1;
         r_prev  <= '0;
         r_word  <= '0;
         r_wr    <= '0;
         r_rd    <= '0;
         r_count <= '0;
         r_timer <= '0;
         r_bit   <= '0;
         r_byte  <= '0;
         r_sent  <= '0;
         r_ovf   <= 1'b0;
      end else begin
         r_tx    <= w_tx;
         r_count <= r_count + (AW+1)'(w_accept) - (AW+1)'(w_pop);
         r_timer <= (r_state == S_IDLE || w_tick) ? '0 : r_timer + 1'b1;
         r_bit   <= w_bit;
         if (en) r_prev <= a0;
         if (w_accept) r_wr <= r_wr + 1'b1;
         if (w_pop) r_rd <= r_rd + 1'b1;
         if (w_push && !w_accept) r_ovf <= 1'b1;
         if (w_pop) begin
            r_word <= r_mem[r_rd];
            r_byte <= '0;
         end else if (r_state == S_STOP && w_tick) begin
            r_word <= r_word << 8;
            r_byte <= r_byte + 1'b1;
         end
         if (r_state == S_STOP && w_tick && w_last) r_sent <= r_sent + 16'd1;
      end
   end
endmodule

// File: tb/tb_a0_uart_monitor.sv
// tb_a0_uart_monitor: checks a0_uart_monitor against a queue-based line model plus pinned literals.
module tb_a0_uart_monitor;
   localparam int CPB = 4, DW = 32, DEPTH = 4, BYTES = DW / 8;
   logic        clk = 0, rst = 0, en = 0;
   logic [31:0] a0 = 0;
   logic        tx, busy, overflow;
   logic [15:0] sent_count;
   int n_checks = 0, n_fail = 0;

   a0_uart_monitor #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .en(en), .a0(a0),
      .tx(tx), .busy(busy), .overflow(overflow), .sent_count(sent_count));

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: pending words, and the exact line levels still to appear for the word on the wire.
   logic [31:0] m_q[$];
   bit          m_line[$];
   logic [31:0] m_prev = 0;
   bit          m_ovf = 0;
   logic [15:0] m_sent = 0;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_q.delete();
         m_line.delete();
         m_prev = 0;
         m_ovf  = 0;
         m_sent = 0;
      end else begin
         bit pop, push;
         logic [31:0] w;
         logic [7:0] by;
         push = 0;
         if (m_line.size() > 0) begin
            void'(m_line.pop_front());
            if (m_line.size() == 0) m_sent++;
         end
         pop = (m_line.size() == 0) && (m_q.size() > 0);
         if (en && a0 !== m_prev) begin
            if (m_q.size() < DEPTH || pop) push = 1;
            else m_ovf = 1;
         end
         if (en) m_prev = a0;
         if (pop) begin
            w = m_q.pop_front();
            for (int b = 0; b < BYTES; b++) begin
               by = 8'(w >> (8 * (BYTES - 1 - b)));
               repeat (CPB) m_line.push_back(1'b0);
               for (int i = 0; i < 8; i++) repeat (CPB) m_line.push_back(by[i]);
               repeat (CPB) m_line.push_back(1'b1);
            end
         end
         if (push) m_q.push_back(a0);
      end
   end

   always @(negedge clk) begin
      chk("tx", {31'b0, tx}, {31'b0, (m_line.size() > 0) ? m_line[0] : 1'b1});
      chk("busy", {31'b0, busy}, {31'b0, (m_line.size() > 0) || (m_q.size() > 0)});
      chk("overflow", {31'b0, overflow}, {31'b0, m_ovf});
      chk("sent_count", {16'b0, sent_count}, {16'b0, m_sent});
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_idle(input int lim);
      int i = 0;
      step(2);
      while (busy && i < lim) begin
         @(negedge clk);
         i++;
      end
      if (busy) chk("idle_timeout", {31'b0, busy}, 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // 1: reset and idle
      step(3);
      rst = 1; en = 1; a0 = 0;
      step(100);
      chk("idle_tx", {31'b0, tx}, 32'd1);
      chk("idle_sent", {16'b0, sent_count}, 32'd0);
      // 2: single word, tx low one edge after the push
      a0 = 32'h0000_00A5;
      step(1);
      chk("single_busy_queued", {31'b0, busy}, 32'd1);
      step(1);
      chk("single_start_k0", {31'b0, tx}, 32'd0);
      step(124);
      chk("single_A5_bit0", {31'b0, tx}, 32'd1);
      step(4);
      chk("single_A5_bit1", {31'b0, tx}, 32'd0);
      step(28);
      chk("single_stop", {31'b0, tx}, 32'd1);
      step(3);
      chk("single_sent_before", {16'b0, sent_count}, 32'd0);
      step(1);
      chk("single_sent_after", {16'b0, sent_count}, 32'd1);
      chk("single_busy_after", {31'b0, busy}, 32'd0);
      // 3: burst of six distinct values into a depth-4 FIFO
      for (int v = 1; v <= 6; v++) begin
         a0 = 32'h0101_0101 * v;
         step(1);
         if (v == 5) chk("burst_ovf_before", {31'b0, overflow}, 32'd0);
      end
      chk("burst_ovf_set", {31'b0, overflow}, 32'd1);
      wait_idle(5 * 160 + 50);
      chk("burst_sent", {16'b0, sent_count}, 32'd6);
      // 4: enable gating
      en = 0; a0 = 7;
      step(3);
      a0 = 9;
      step(3);
      chk("gate_no_push", {31'b0, busy}, 32'd0);
      en = 1;
      wait_idle(250);
      chk("gate_sent", {16'b0, sent_count}, 32'd7);
      // 5: repeated values
      a0 = 32'h11; step(2);
      a0 = 32'h22; step(2);
      a0 = 32'h11;
      wait_idle(3 * 160 + 50);
      chk("repeat_sent", {16'b0, sent_count}, 32'd10);
      // 6: reset in the DATA state of byte 2 with two words queued
      a0 = 32'h1234_5678; step(1);
      a0 = 32'h0F0F_0F0F; step(1);
      a0 = 32'hAAAA_AAAA; step(85);
      chk("mid_tx_low", {31'b0, tx}, 32'd0);
      #2;
      rst = 0; a0 = 0;
      #1;
      chk("rst_tx_immediate", {31'b0, tx}, 32'd1);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_sent", {16'b0, sent_count}, 32'd0);
      chk("rst_ovf", {31'b0, overflow}, 32'd0);
      step(2);
      rst = 1;
      step(200);
      chk("post_rst_quiet", {31'b0, busy}, 32'd0);
      a0 = 32'h5A;
      wait_idle(250);
      chk("post_rst_sent", {16'b0, sent_count}, 32'd1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/a0_uart_monitor.md
Name: a0_uart_monitor

Overview:
- Downstream observer of the single-cycle CPU's `a0` result register.
- Samples `a0` every enabled cycle and detects value changes.
- Queues each new value in a small FIFO and serialises it over a UART 8N1 line, so program results can be read off-chip without a debugger.
- Sits between the CPU top level and the board TX pin.

Parameters:
- DATA_WIDTH, 32: width of the `a0` word. Must be a multiple of 8; BYTES = DATA_WIDTH/8.
- CLKS_PER_BIT, 16: clock cycles per UART bit. Must be ≥ 2.
- FIFO_DEPTH, 4: number of queued words. Power of two, ≥ 2.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  sample enable; `a0` is compared only when en=1.
- a0  in  DATA_WIDTH  CPU result register value.
- tx  out  1  UART serial output; idles high.
- busy  out  1  high when a word is being sent or the FIFO is non-empty.
- overflow  out  1  sticky flag: a changed value was dropped because the FIFO was full.
- sent_count  out  16  number of words fully transmitted; wraps modulo 2^16.

Behaviour:
- Reset (rst=0, asynchronous):
  - tx=1, busy=0, overflow=0, sent_count=0.
  - FIFO emptied, prev_a0=0, FSM set to IDLE.
  - A frame in progress is abandoned with no partial completion; tx rises immediately.
- Change detect:
  - On an edge with en=1 and a0≠prev_a0, push a0 into the FIFO.
  - On every edge with en=1, prev_a0<=a0.
  - With en=0, neither prev_a0 nor the FIFO changes.
  - The first nonzero value after reset counts as a change.
- FIFO:
  - Synchronous, registered count.
  - A push while full is dropped and sets overflow=1; overflow is cleared only by reset.
  - A simultaneous push and pop while full is accepted: the pop frees the slot in the same edge.
  - A simultaneous push and pop while empty is not allowed to bypass; the pop requires count>0 before the edge.
- Serialiser FSM states: IDLE, START, DATA, STOP. Counters: bit timer, bit index 0–7, byte index 0..BYTES-1.
  - IDLE:
    - If the FIFO is non-empty at an edge, pop the head into the shift word, set byte index=0, tx<=0, and go to START.
    - A value pushed at edge E therefore drives tx low at edge E+1 when the serialiser is idle.
  - START: hold tx=0 for CLKS_PER_BIT cycles, then tx<=data bit 0 and go to DATA.
  - DATA:
    - Each bit is held CLKS_PER_BIT cycles, LSB first.
    - After bit 7, tx<=1 and go to STOP.
  - STOP: hold tx=1 for CLKS_PER_BIT cycles, then:
    - If more bytes remain in the word: increment the byte index, tx<=0, go to START. There is no inter-byte gap.
    - Otherwise: sent_count<=sent_count+1. If the FIFO is non-empty, pop the next word, tx<=0, and go to START (no gap). Else tx stays 1 and go to IDLE.
- Byte order: most significant byte first.
- Word duration: BYTES×10×CLKS_PER_BIT cycles, which is 640 cycles at the defaults.
- busy = (state≠IDLE) | (FIFO count≠0), registered-output equivalent. There is no combinational path from a0 to tx.

Test Plan:
1. Reset and idle:
   - Stimulus: hold rst=0 for 3 cycles, release, en=1, a0=0 for 100 cycles.
   - Required response: tx=1, busy=0, overflow=0, sent_count=0 throughout.
2. Single word:
   - Stimulus: CLKS_PER_BIT=4; a0 changes 0→0x000000A5 at edge E.
   - Required response: tx low from E+1.
   - Frames carry bytes 00,00,00,A5, each 4-cycle bits LSB first (A5 → 1,0,1,0,0,1,0,1).
   - sent_count=1 at E+161; busy=0 afterwards.
3. Burst and overflow:
   - Stimulus: DEPTH=4; a0 takes 6 distinct values on consecutive edges E..E+5.
   - Required response: v1 is popped at E+1 and v2–v5 fill the FIFO.
   - v6 is dropped and overflow=1 from E+5.
   - Exactly 5 words are sent back-to-back with no idle tx between them; final sent_count=5.
4. Enable gating:
   - Stimulus: en=0 while a0 changes 0→7→9, then en=1 with a0=9 held.
   - Required response: one word 0x00000009 is sent; no word for 7.
5. Repeat values:
   - Stimulus: a0 goes 0x11→0x22→0x11, each held 2 cycles, then held.
   - Required response: three words 0x11, 0x22, 0x11 are sent; holding a value adds nothing.
6. Reset mid-frame:
   - Stimulus: assert rst during the DATA state of byte 2 with 2 words queued.
   - Required response: tx=1 immediately (before the next edge), FIFO empty, sent_count=0.
   - No further frames after release until a new change occurs.
